// File: rtl/invert.sv
// invert: bit-serial two's-complement negator.
//
// The operand arrives one bit per clock, LSB first, on i. The negated operand
// leaves on y in the same cycle. Bits pass unchanged up to and including the
// first 1, and every later bit is inverted.
//
// Parameters
//   WORD_LEN : operand length for auto-restart. 0 disables auto-restart, so
//              words are delimited only by r.
//   CNT_W    : bit counter width. Only used when WORD_LEN > 0, and it must
//              satisfy 2**CNT_W > WORD_LEN.
//
// Ports
//   i     in   serial operand bit, LSB first
//   r     in   asynchronous active-high reset; also marks a new operand
//   t_clk in   clock, rising edge
//   y     out  serial result bit (combinational from i)
//
// States
//   state  | meaning
//   SCAN   | no 1 seen yet in this operand, y = i
//   INVERT | first 1 already passed, y = ~i

module invert #(
   parameter int WORD_LEN = 0,
   parameter int CNT_W    = 8
) (
   input  logic i,
   input  logic r,
   input  logic t_clk,
   output logic y
);

   localparam logic [0:0] SCAN   = 1'b0;
   localparam logic [0:0] INVERT = 1'b1;

   logic [0:0] seen_one;
   logic [0:0] seen_one_nxt;
   logic       word_end;

   // Mealy output. The state encoding doubles as the inversion mask.
   assign y = i ^ seen_one[0];

   always_comb begin
      seen_one_nxt = seen_one;
      if (word_end) begin
         seen_one_nxt = SCAN;
      end else if ((seen_one == SCAN) && i) begin
         seen_one_nxt = INVERT;
      end
   end

   always_ff @(posedge t_clk or posedge r) begin
      if (r) begin
         seen_one <= SCAN;
      end else begin
         seen_one <= seen_one_nxt;
      end
   end

   generate
      if (WORD_LEN > 0) begin : g_cnt
         localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_LEN - 1);

         logic [CNT_W-1:0] bit_cnt;

         // This edge accepts the last bit of the word. The next bit is a new LSB.
         assign word_end = (bit_cnt == LAST_BIT);

         always_ff @(posedge t_clk or posedge r) begin
            if (r) begin
               bit_cnt <= '0;
            end else if (word_end) begin
               bit_cnt <= '0;
            end else begin
               bit_cnt <= bit_cnt + CNT_W'(1);
            end
         end
      end else begin : g_no_cnt
         assign word_end = 1'b0;
      end
   endgenerate

endmodule

// File: tb/tb_invert.sv
module tb_invert;

   localparam int WL = 4;

   logic t_clk = 1'b0;
   logic i = 1'b0;
   logic r = 1'b0;
   logic y0;
   logic y4;
   logic started = 1'b0;

   int n_chk  = 0;
   int n_fail = 0;

   always #10 t_clk = ~t_clk;

   invert #(.WORD_LEN(0)) dut0 (.i(i), .r(r), .t_clk(t_clk), .y(y0));
   invert #(.WORD_LEN(WL), .CNT_W(3)) dut4 (.i(i), .r(r), .t_clk(t_clk), .y(y4));

   // The model keeps the bits accepted so far in the current word. The
   // expected output is bit pos of the arithmetic negation of those bits plus
   // the current bit.
   logic [63:0] acc0 = '0;
   logic [63:0] acc4 = '0;
   int pos0 = 0;
   int pos4 = 0;

   function automatic logic neg_bit(logic [63:0] acc, int pos, logic b);
      logic [63:0] v;
      logic [63:0] n;
      v = acc | ({63'b0, b} << pos);
      n = -v;
      return n[pos];
   endfunction

   always @(posedge t_clk or posedge r) begin
      if (r) begin
         acc0 = '0; pos0 = 0;
         acc4 = '0; pos4 = 0;
      end else begin
         acc0 = acc0 | ({63'b0, i} << pos0);
         if (pos0 < 63) pos0 = pos0 + 1;
         acc4 = acc4 | ({63'b0, i} << pos4);
         pos4 = pos4 + 1;
         if (pos4 == WL) begin
            acc4 = '0; pos4 = 0;
         end
      end
   end

   task automatic check(input string name, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: y=%b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge t_clk) begin
      if (started) begin
         check("model_w0", y0, r ? i : neg_bit(acc0, pos0, i));
         check("model_w4", y4, r ? i : neg_bit(acc4, pos4, i));
      end
   end

   task automatic drive(input logic b, input logic rr);
      @(posedge t_clk);
      #1;
      i = b;
      r = rr;
   endtask

   task automatic step(input string name, input logic b, input logic rr,
                       input logic e0, input logic e4);
      drive(b, rr);
      @(negedge t_clk);
      #1;
      check({name, "_w0"}, y0, e0);
      check({name, "_w4"}, y4, e4);
   endtask

   initial begin
      int len;
      // Reset hold: y follows i.
      r = 1'b1;
      started = 1'b1;
      step("rst_hold0", 1'b0, 1'b1, 1'b0, 1'b0);
      step("rst_hold1", 1'b1, 1'b1, 1'b1, 1'b1);
      step("rst_hold2", 1'b1, 1'b1, 1'b1, 1'b1);

      // 0b0010 gives -2.
      step("neg2_b0", 1'b0, 1'b0, 1'b0, 1'b0);
      step("neg2_b1", 1'b1, 1'b0, 1'b1, 1'b1);
      step("neg2_b2", 1'b0, 1'b0, 1'b1, 1'b1);
      step("neg2_b3", 1'b0, 1'b0, 1'b1, 1'b1);

      // dut0 is in INVERT. dut4 has just auto-restarted.
      @(posedge t_clk);
      #1;
      i = 1'b1;
      r = 1'b0;
      #2;
      check("pre_rst_w0", y0, 1'b0);
      check("pre_rst_w4", y4, 1'b1);
      #2;
      r = 1'b1;
      #1;
      check("async_rst_w0", y0, 1'b1);
      check("async_rst_w4", y4, 1'b1);

      // After reset: 1,0,1,0,0,1,1.
      step("mid_b0", 1'b1, 1'b0, 1'b1, 1'b1);
      step("mid_b1", 1'b0, 1'b0, 1'b1, 1'b1);
      step("mid_b2", 1'b1, 1'b0, 1'b0, 1'b0);
      step("mid_b3", 1'b0, 1'b0, 1'b1, 1'b1);
      step("mid_b4", 1'b0, 1'b0, 1'b1, 1'b0);
      step("mid_b5", 1'b1, 1'b0, 1'b0, 1'b1);
      step("mid_b6", 1'b1, 1'b0, 1'b0, 1'b0);

      // All-zero 8-bit word.
      step("zero_rst", 1'b0, 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 8; k++) step("zero_b", 1'b0, 1'b0, 1'b0, 1'b0);

      // Most-negative 4-bit word 0,0,0,1.
      step("mneg_rst", 1'b0, 1'b1, 1'b0, 1'b0);
      step("mneg_b0", 1'b0, 1'b0, 1'b0, 1'b0);
      step("mneg_b1", 1'b0, 1'b0, 1'b0, 1'b0);
      step("mneg_b2", 1'b0, 1'b0, 1'b0, 1'b0);
      step("mneg_b3", 1'b1, 1'b0, 1'b1, 1'b1);

      // Back-to-back words 1,0,0,0 and 0,1,0,0 with no reset in between.
      step("b2b_rst", 1'b0, 1'b1, 1'b0, 1'b0);
      step("b2b_b0", 1'b1, 1'b0, 1'b1, 1'b1);
      step("b2b_b1", 1'b0, 1'b0, 1'b1, 1'b1);
      step("b2b_b2", 1'b0, 1'b0, 1'b1, 1'b1);
      step("b2b_b3", 1'b0, 1'b0, 1'b1, 1'b1);
      step("b2b_b4", 1'b0, 1'b0, 1'b1, 1'b0);
      step("b2b_b5", 1'b1, 1'b0, 1'b0, 1'b1);
      step("b2b_b6", 1'b0, 1'b0, 1'b1, 1'b1);
      step("b2b_b7", 1'b0, 1'b0, 1'b1, 1'b1);

      // Random words separated by reset pulses. These are checked by the model only.
      for (int w = 0; w < 12; w++) begin
         drive(1'($urandom_range(0, 1)), 1'b1);
         len = int'($urandom_range(1, 20));
         for (int k = 0; k < len; k++) drive(1'($urandom_range(0, 1)), 1'b0);
      end
      @(posedge t_clk);
      @(negedge t_clk);
      #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
